// File: rtl/bfs_pkg.sv
// rtl/bfs_pkg.sv - shared encodings, sizes and FSM states for the BFS update packer
package bfs_pkg;

    localparam logic [1:0] CTRL_IDLE = 2'd0;
    localparam logic [1:0] CTRL_LOAD = 2'd1;
    localparam logic [1:0] CTRL_TRAV = 2'd2;

    localparam int WORD_W  = 32;
    localparam int LANES   = 16;
    localparam int LINE_W  = LANES * WORD_W;
    localparam int CNT_W   = 5;
    localparam int ENTRY_W = LINE_W + CNT_W;

    localparam logic [WORD_W-1:0] PAD_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [LINE_W-1:0] pad_line();
        return {LANES{PAD_WORD}};
    endfunction

endpackage

// File: rtl/line_fifo2.sv
// rtl/line_fifo2.sv - two-entry valid/ready FIFO with simultaneous push and pop
module line_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign m_tvalid = !empty;
    assign m_tdata  = mem[rd_ptr];
    assign pop      = m_tvalid && m_tready;
    // When full, a push lands in the slot being popped this same edge.
    assign push     = s_tvalid && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_tdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bfs_update_packer.sv
// rtl/bfs_update_packer.sv - packs 32-bit frontier updates into 16-word lines for the AFU write path
module bfs_update_packer
    import bfs_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        control_in,
    input  logic [31:0]       upd_in,
    input  logic              upd_valid,
    input  logic              last_input_in,
    output logic [LINE_W-1:0] line_out,
    output logic [4:0]        line_words,
    output logic              line_valid,
    input  logic              line_ready,
    output logic              done_out,
    output logic              overflow,
    output logic [31:0]       upd_count
);

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cnt;
    logic [LINE_W-1:0]  acc;
    logic [LINE_W-1:0]  acc_upd;
    logic               accept;
    logic               line_full;
    logic               push_valid;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               drop;

    assign accept    = (state == ST_COLLECT) && upd_valid && (control_in == CTRL_TRAV);
    assign line_full = accept && (cnt == 4'(LANES - 1));

    always_comb begin
        acc_upd = acc;
        acc_upd[{cnt, 5'b0} +: WORD_W] = upd_in;
    end

    // Only one push source can be active: completion happens in COLLECT, partial flush in FLUSH.
    always_comb begin
        push_valid = 1'b0;
        push_data  = '0;
        if (line_full) begin
            push_valid = 1'b1;
            push_data  = {acc_upd, 5'd16};
        end else if ((state == ST_FLUSH) && (cnt != 4'd0)) begin
            push_valid = 1'b1;
            push_data  = {acc, {1'b0, cnt}};
        end
    end

    assign drop = push_valid && fifo_full && !line_ready;

    line_fifo2 #(
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (push_data),
        .s_tvalid (push_valid),
        .m_tdata  (head),
        .m_tvalid (line_valid),
        .m_tready (line_ready),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign line_out   = head[ENTRY_W-1:CNT_W];
    assign line_words = head[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            acc       <= pad_line();
            upd_count <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                upd_count <= upd_count + 32'd1;
                if (line_full) begin
                    cnt <= 4'd0;
                    acc <= pad_line();
                end else begin
                    cnt <= cnt + 4'd1;
                    acc <= acc_upd;
                end
            end
            if (state == ST_FLUSH) begin
                cnt <= 4'd0;
                acc <= pad_line();
            end
            if (state == ST_DONE) begin
                upd_count <= '0;
                overflow  <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        done_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (control_in == CTRL_TRAV) state_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (last_input_in) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done_out  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bfs_update_packer.sv
// tb/tb_bfs_update_packer.sv - directed self-checking bench for bfs_update_packer
module tb_bfs_update_packer;
    import bfs_pkg::*;

    logic              clk;
    logic              rst;
    logic [1:0]        control_in;
    logic [31:0]       upd_in;
    logic              upd_valid;
    logic              last_input_in;
    logic [LINE_W-1:0] line_out;
    logic [4:0]        line_words;
    logic              line_valid;
    logic              line_ready;
    logic              done_out;
    logic              overflow;
    logic [31:0]       upd_count;

    int errors = 0;
    int checks = 0;
    int lat;

    logic [LINE_W-1:0] got_lines [$];
    logic [4:0]        got_words [$];

    bfs_update_packer dut (
        .clk           (clk),
        .rst           (rst),
        .control_in    (control_in),
        .upd_in        (upd_in),
        .upd_valid     (upd_valid),
        .last_input_in (last_input_in),
        .line_out      (line_out),
        .line_words    (line_words),
        .line_valid    (line_valid),
        .line_ready    (line_ready),
        .done_out      (done_out),
        .overflow      (overflow),
        .upd_count     (upd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (line_valid && line_ready) begin
            got_lines.push_back(line_out);
            got_words.push_back(line_words);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        upd_valid = 1'b1;
        upd_in    = w;
        cyc();
        upd_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done_out && n < 50) begin
            cyc();
            n++;
        end
        check("done_seen", {31'd0, done_out}, 32'd1);
    endtask

    task automatic finish_pass(output int n);
        last_input_in = 1'b1;
        cyc();
        last_input_in = 1'b0;
        wait_done(n);
    endtask

    task automatic check_line(input string tag, input int idx, input int nw, input logic [31:0] base);
        logic [LINE_W-1:0] l;
        logic [31:0]       exp;
        if (idx < got_lines.size()) begin
            l = got_lines[idx];
            check({tag, "_words"}, {27'd0, got_words[idx]}, nw);
            for (int k = 0; k < LANES; k++) begin
                exp = (k < nw) ? base + k : PAD_WORD;
                check($sformatf("%s_w%0d", tag, k), l[k*32 +: 32], exp);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, line_valid}, 32'd0);
        check({tag, "_words"}, {27'd0, line_words}, 32'd0);
        check({tag, "_out0"}, {31'd0, (line_out == '0)}, 32'd1);
        check({tag, "_done"}, {31'd0, done_out}, 32'd0);
        check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
        check({tag, "_cnt"}, upd_count, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        control_in = CTRL_IDLE;
        upd_in = '0;
        upd_valid = 1'b0;
        last_input_in = 1'b0;
        line_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        check_idle_outputs("reset");

        // Full line of 0..15
        control_in = CTRL_TRAV;
        cyc();
        for (int i = 0; i < 16; i++) begin
            upd_valid = 1'b1;
            upd_in = i;
            cyc();
        end
        upd_valid = 1'b0;
        check("full_valid_rise", {31'd0, line_valid}, 32'd1);
        check("full_words_out", {27'd0, line_words}, 32'd16);
        cyc();
        check("full_valid_fall", {31'd0, line_valid}, 32'd0);
        check("full_cnt", upd_count, 32'd16);
        finish_pass(lat);
        check("full_cnt_at_done", upd_count, 32'd16);
        check("full_nlines", got_lines.size(), 32'd1);
        check_line("full", 0, 16, 32'd0);
        cyc();
        check("full_done_fall", {31'd0, done_out}, 32'd0);
        check("full_cnt_clr", upd_count, 32'd0);

        // Partial flush
        got_lines.delete();
        got_words.delete();
        cyc();
        for (int i = 0; i < 3; i++) send(32'd100 + i);
        finish_pass(lat);
        check("part_nlines", got_lines.size(), 32'd1);
        check_line("part", 0, 3, 32'd100);
        cyc();

        // Last input coinciding with the 16th word
        got_lines.delete();
        got_words.delete();
        cyc();
        for (int i = 0; i < 15; i++) send(32'd200 + i);
        upd_valid = 1'b1;
        upd_in = 32'd215;
        last_input_in = 1'b1;
        cyc();
        upd_valid = 1'b0;
        last_input_in = 1'b0;
        wait_done(lat);
        check("simul_nlines", got_lines.size(), 32'd1);
        check_line("simul", 0, 16, 32'd200);
        cyc();

        // Backpressure and overflow
        got_lines.delete();
        got_words.delete();
        line_ready = 1'b0;
        cyc();
        for (int i = 0; i < 48; i++) send(i);
        check("bp_ovf", {31'd0, overflow}, 32'd1);
        check("bp_valid", {31'd0, line_valid}, 32'd1);
        check("bp_head_words", {27'd0, line_words}, 32'd16);
        check("bp_head_w0", line_out[31:0], 32'd0);
        check("bp_cnt", upd_count, 32'd48);
        check("bp_nlines_held", got_lines.size(), 32'd0);
        line_ready = 1'b1;
        finish_pass(lat);
        check("bp_ovf_at_done", {31'd0, overflow}, 32'd1);
        check("bp_nlines", got_lines.size(), 32'd2);
        check_line("bp0", 0, 16, 32'd0);
        check_line("bp1", 1, 16, 32'd16);
        cyc();
        check("bp_ovf_clr", {31'd0, overflow}, 32'd0);

        // Gating and empty pass
        got_lines.delete();
        got_words.delete();
        control_in = CTRL_LOAD;
        for (int i = 0; i < 3; i++) send(32'd400 + i);
        control_in = CTRL_TRAV;
        cyc();
        control_in = CTRL_LOAD;
        for (int i = 0; i < 3; i++) send(32'd410 + i);
        check("gate_cnt", upd_count, 32'd0);
        check("gate_valid", {31'd0, line_valid}, 32'd0);
        control_in = CTRL_TRAV;
        finish_pass(lat);
        check("empty_latency", lat, 32'd2);
        check("empty_nlines", got_lines.size(), 32'd0);
        cyc();

        // Reset mid-pass
        cyc();
        for (int i = 0; i < 5; i++) send(32'd500 + i);
        check("mid_cnt", upd_count, 32'd5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        control_in = CTRL_IDLE;
        check_idle_outputs("midrst");
        got_lines.delete();
        got_words.delete();
        control_in = CTRL_TRAV;
        cyc();
        for (int i = 0; i < 16; i++) send(32'd300 + i);
        finish_pass(lat);
        check("rst_nlines", got_lines.size(), 32'd1);
        check_line("rst", 0, 16, 32'd300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
